// File: rtl/ahb_lite_dma_copier.sv
// ahb_lite_dma_copier
//   Single-channel AHB-Lite master. It copies a block of 32-bit words from a
//   source to a destination address, one single read followed by one single
//   write per word, in ascending address order.
//
// Ports
//   HCLK, HRESETn              clock, asynchronous active-low reset
//   start                      one-cycle job request, honoured only when idle
//   srcAddr, dstAddr           byte addresses, forced to word alignment on start
//   wordCount                  words to copy (0 = finish without bus traffic)
//   busy / done / error        job status; done is a one-cycle pulse, error is
//                              sticky until the next accepted start
//   HADDR, HTRANS, HWRITE,
//   HSIZE, HBURST, HPROT,
//   HMASTLOCK, HWDATA          AHB-Lite master outputs
//   HREADY, HRDATA, HRESP      AHB-Lite slave responses
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// RD_ADDR | NONSEQ read address phase at src
// RD_DATA | read data phase, capture HRDATA
// WR_ADDR | NONSEQ write address phase at dst
// WR_DATA | write data phase, HWDATA driven from the captured word
// ABORT   | second cycle of an ERROR response
// FIN     | done pulse, then back to IDLE
module ahb_lite_dma_copier #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   start,
    input  logic [31:0]            srcAddr,
    input  logic [31:0]            dstAddr,
    input  logic [COUNT_WIDTH-1:0] wordCount,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic                   HMASTLOCK,
    output logic [31:0]            HWDATA,
    input  logic                   HREADY,
    input  logic [31:0]            HRDATA,
    input  logic                   HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_ABORT,
        S_FIN
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t                 state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [31:0]            data_q, data_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        HTRANS  = TRANS_IDLE;
        HADDR   = '0;
        HWRITE  = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = srcAddr & 32'hFFFF_FFFC;
                    dst_d   = dstAddr & 32'hFFFF_FFFC;
                    cnt_d   = wordCount;
                    err_d   = 1'b0;
                    state_d = (wordCount == '0) ? S_FIN : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                HTRANS = TRANS_NONSEQ;
                HADDR  = src_q;
                if (HREADY) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                // ERROR is recognised on its first (HREADY=0) cycle.
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else if (HREADY) begin
                    data_d  = HRDATA;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                HTRANS = TRANS_NONSEQ;
                HADDR  = dst_q;
                HWRITE = 1'b1;
                if (HREADY) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = S_ABORT;
                end else if (HREADY) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - 1'b1;
                    // Remaining count of one means this was the last word.
                    state_d = (cnt_q == COUNT_WIDTH'(1)) ? S_FIN : S_RD_ADDR;
                end
            end
            S_ABORT: begin
                if (HREADY) state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign error     = err_q;
    assign HWDATA    = data_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_dma_copier.sv
// Testbench for ahb_lite_dma_copier: an AHB-Lite RAM slave with planned wait
// states and error responses, a job-level reference model that predicts the
// bus transfer sequence, written data and done timing, and a monitor that
// checks the DUT against those predictions.
module tb_ahb_lite_dma_copier;

    localparam int CW = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          start;
    logic [31:0]   srcAddr, dstAddr;
    logic [CW-1:0] wordCount;
    logic          busy, done, error;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic          HMASTLOCK;
    logic [31:0]   HWDATA;
    logic          HREADY = 1'b1;
    logic [31:0]   HRDATA = 32'h0;
    logic          HRESP  = 1'b0;

    ahb_lite_dma_copier #(.COUNT_WIDTH(CW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .srcAddr(srcAddr), .dstAddr(dstAddr), .wordCount(wordCount),
        .busy(busy), .done(done), .error(error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory shared by slave and reference model ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
    typedef struct { int unsigned aw; int unsigned dw; bit err; } plan_t;
    typedef struct { int unsigned cyc; logic err; } done_t;

    xfer_t       exp_xfer[$];
    plan_t       plan_q[$];
    done_t       exp_done[$];
    logic [31:0] cm_a[$];
    logic [31:0] cm_d[$];

    // ---------------- slave: consumes one plan entry per transfer ----------------
    bit          ap_act = 0, dp_act = 0, err_stage = 0;
    plan_t       cur;
    logic [31:0] dp_addr;
    logic        dp_wr;

    always @(negedge HCLK) begin
        HRESP  = 1'b0;
        HREADY = 1'b1;
        HRDATA = $urandom;
        if (!HRESETn) begin
            ap_act = 0; dp_act = 0; err_stage = 0;
        end else if (dp_act) begin
            if (cur.dw > 0) begin
                HREADY = 1'b0;
                cur.dw--;
            end else if (cur.err) begin
                HRESP = 1'b1;
                if (!err_stage) begin
                    HREADY = 1'b0;
                    err_stage = 1;
                end else begin
                    err_stage = 0;
                    dp_act = 0;
                end
            end else begin
                if (dp_wr) mem[dp_addr] = HWDATA;
                else       HRDATA = mem_rd(dp_addr);
                dp_act = 0;
            end
        end else if (HTRANS == 2'b10) begin
            if (!ap_act) begin
                ap_act = 1;
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else                   cur = '{0, 0, 1'b0};
            end
            if (cur.aw > 0) begin
                HREADY = 1'b0;
                cur.aw--;
            end else begin
                ap_act  = 0;
                dp_act  = 1;
                dp_addr = HADDR;
                dp_wr   = HWRITE;
            end
        end
    end

    // ---------------- monitor ----------------
    bit          wr_pend = 0, dp_mon = 0, stall_prev = 0;
    logic [31:0] wr_exp, stall_addr;
    logic        stall_wr;
    int unsigned done_cnt = 0;

    always @(negedge HCLK) begin
        xfer_t x;
        done_t d;
        #2;
        if (!HRESETn) begin
            wr_pend = 0; dp_mon = 0; stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("addr_hold_trans", 32'(HTRANS), 32'h2);
                chk("addr_hold_addr", HADDR, stall_addr);
                chk("addr_hold_write", 32'(HWRITE), 32'(stall_wr));
                stall_prev = 0;
            end
            if (dp_mon && HREADY) begin
                if (wr_pend) chk("hwdata", HWDATA, wr_exp);
                wr_pend = 0;
                dp_mon  = 0;
            end
            if (HTRANS == 2'b10) begin
                if (HREADY) begin
                    if (exp_xfer.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got addr 0x%0h write %0d, want no transfer", HADDR, HWRITE);
                    end else begin
                        x = exp_xfer.pop_front();
                        chk("xfer_addr", HADDR, x.addr);
                        chk("xfer_write", 32'(HWRITE), 32'(x.wr));
                        if (x.wr) begin
                            wr_pend = 1;
                            wr_exp  = x.data;
                        end
                    end
                    chk("ctl_const", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));
                    dp_mon = 1;
                end else begin
                    stall_prev = 1;
                    stall_addr = HADDR;
                    stall_wr   = HWRITE;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", 32'(busy), 32'h1);
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, want 0 (cycle %0d)", cyc);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_error", 32'(error), 32'(d.err));
                end
            end
        end
    end

    // ---------------- reference model and job stimulus ----------------
    task automatic issue_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                             input int err_t, input int aw_lo, input int aw_hi,
                             input int dw_lo, input int dw_hi);
        logic [31:0] ov [logic [31:0]];
        logic [31:0] sa, da, v;
        int unsigned sum;
        int          t;
        bit          stop;
        plan_t       p;
        xfer_t       x;
        done_t       d;
        sa = src & 32'hFFFF_FFFC;
        da = dst & 32'hFFFF_FFFC;
        sum = 0; t = 0; stop = 0; v = '0;
        cm_a.delete();
        cm_d.delete();
        for (int i = 0; i < n && !stop; i++) begin
            for (int k = 0; k < 2 && !stop; k++) begin
                p.aw  = $urandom_range(aw_hi, aw_lo);
                p.dw  = $urandom_range(dw_hi, dw_lo);
                p.err = (t == err_t);
                if (k == 0) begin
                    x.addr = sa + 32'(4 * i);
                    x.wr   = 1'b0;
                    x.data = '0;
                    v = ov.exists(x.addr) ? ov[x.addr] : mem_rd(x.addr);
                end else begin
                    x.addr = da + 32'(4 * i);
                    x.wr   = 1'b1;
                    x.data = v;
                    if (!p.err) begin
                        ov[x.addr] = v;
                        cm_a.push_back(x.addr);
                        cm_d.push_back(v);
                    end
                end
                // address phase + data phase, plus the ABORT cycle on error
                sum += 2 + p.aw + p.dw + (p.err ? 1 : 0);
                plan_q.push_back(p);
                exp_xfer.push_back(x);
                if (p.err) stop = 1;
                t++;
            end
        end
        @(negedge HCLK);
        srcAddr   = src;
        dstAddr   = dst;
        wordCount = CW'(n);
        start     = 1'b1;
        d.cyc = cyc + 1 + sum;
        d.err = stop;
        exp_done.push_back(d);
        @(negedge HCLK);
        start     = 1'b0;
        srcAddr   = $urandom;
        dstAddr   = $urandom;
        wordCount = CW'($urandom);
        #3;
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("error_cleared", 32'(error), 32'h0);
    endtask

    task automatic pulse_start_again();
        @(negedge HCLK);
        start     = 1'b1;
        srcAddr   = $urandom;
        dstAddr   = $urandom;
        wordCount = CW'($urandom_range(5, 1));
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic flush_all();
        exp_xfer.delete();
        exp_done.delete();
        plan_q.delete();
    endtask

    task automatic finish_job();
        bit got;
        got = 0;
        for (int w = 0; w < 2000 && !got; w++) begin
            @(negedge HCLK);
            #4;
            if (exp_done.size() == 0) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 2000 cycles, want done pulse");
            HRESETn = 1'b0;
            repeat (2) @(negedge HCLK);
            flush_all();
            HRESETn = 1'b1;
        end else begin
            @(negedge HCLK);
            #4;
            chk("busy_after_done", 32'(busy), 32'h0);
            chk("xfers_left", 32'(exp_xfer.size()), 32'h0);
            foreach (cm_a[i]) chk("mem_word", mem_rd(cm_a[i]), cm_d[i]);
        end
        plan_q.delete();
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input int err_t, input int aw_lo, input int aw_hi,
                           input int dw_lo, input int dw_hi, input bit repulse);
        issue_job(src, dst, n, err_t, aw_lo, aw_hi, dw_lo, dw_hi);
        if (repulse) pulse_start_again();
        finish_job();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
        chk({tag, "_haddr"}, HADDR, 32'h0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
        chk({tag, "_hwdata"}, HWDATA, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_error"}, 32'(error), 32'h0);
    endtask

    initial begin
        bit          found;
        int unsigned dc0;
        HRESETn = 1'b0; start = 1'b0; srcAddr = '0; dstAddr = '0; wordCount = '0;
        repeat (3) @(negedge HCLK);
        #3;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // zero-wait 4-word copy: done at start + 17
        run_job(32'h0000_0000, 32'h0000_0100, 4, -1, 0, 0, 0, 0, 0);
        // empty job
        run_job(32'h0000_0200, 32'h0000_0300, 0, -1, 0, 0, 0, 0, 0);
        // two wait states on every data phase
        run_job(32'h0000_0400, 32'h0000_0500, 3, -1, 0, 0, 2, 2, 0);
        // address-phase stalls to exercise HADDR/HWRITE hold
        run_job(32'h0000_0600, 32'h0000_0700, 3, -1, 1, 3, 0, 1, 0);
        // ERROR on the second read of five words
        run_job(32'h0000_0800, 32'h0000_0900, 5, 2, 0, 0, 0, 0, 0);
        // ERROR on a write, then the following job clears error
        run_job(32'h0000_0A00, 32'h0000_0B00, 3, 3, 0, 1, 0, 1, 0);
        // address wrap and low-bit masking
        run_job(32'hFFFF_FFFC, 32'h0000_0C00, 2, -1, 0, 0, 0, 0, 0);
        run_job(32'h0000_0103, 32'h0000_0D02, 2, -1, 0, 0, 0, 0, 0);
        // overlapping regions, destination one word above source
        run_job(32'h0000_0E00, 32'h0000_0E04, 4, -1, 0, 1, 0, 1, 1);

        // restart attempt mid-job, then reset during a write address phase
        issue_job(32'h0000_0040, 32'h0000_0400, 3, -1, 0, 0, 0, 0);
        pulse_start_again();
        found = 0;
        for (int w = 0; w < 50 && !found; w++) begin
            @(negedge HCLK);
            #3;
            if (HTRANS == 2'b10 && HWRITE) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wr_addr_timeout: got no write address phase, want one within 50 cycles");
        end
        dc0 = done_cnt;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        flush_all();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(negedge HCLK);
        #4;
        chk("no_done_after_reset", done_cnt, dc0);
        chk("idle_after_reset", 32'(busy), 32'h0);

        // randomized jobs
        for (int j = 0; j < 24; j++) begin
            int          n;
            int          et;
            logic [31:0] s0, d0;
            n  = $urandom_range(6, 0);
            s0 = 32'h0000_1000 + 32'($urandom_range(63, 0) * 4) + 32'($urandom_range(3, 0));
            d0 = 32'h0000_1000 + 32'($urandom_range(63, 0) * 4);
            et = -1;
            if (n > 0 && $urandom_range(3, 0) == 0) et = $urandom_range(2 * n - 1, 0);
            run_job(s0, d0, n, et, 0, 2, 0, 2, (n > 0) && ($urandom_range(1, 0) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
